// File: rtl/bip_pkg.sv
// Shared types and constants for the BIP debug/run controller.
package bip_pkg;

  localparam int OP_W        = 5;
  localparam logic [OP_W-1:0] OP_HLT = 5'd0;
  localparam int FRAME_BYTES = 6;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_STEP_WAIT,
    ST_REPORT,
    ST_DONE
  } dbg_state_e;

endpackage

// File: rtl/bip_debug_ctrl_if.sv
// Host/UART/core-facing signal bundle of the BIP debug controller.
interface bip_debug_ctrl_if #(
  parameter int PC_W  = 11,
  parameter int ACC_W = 16
);
  import bip_pkg::*;

  logic             start;
  logic             step_mode;
  logic             step;
  logic [OP_W-1:0]  opcode;
  logic [PC_W-1:0]  pc;
  logic [ACC_W-1:0] acc;
  logic             tx_done;
  logic             cpu_en;
  logic             cpu_rst;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             busy;
  logic             halted;

  modport slave (
    input  start, step_mode, step, opcode, pc, acc, tx_done,
    output cpu_en, cpu_rst, tx_data, tx_start, busy, halted
  );

  modport master (
    output start, step_mode, step, opcode, pc, acc, tx_done,
    input  cpu_en, cpu_rst, tx_data, tx_start, busy, halted
  );

endinterface

// File: rtl/bip_dbg_tx_seq.sv
// Streams a captured status frame to the UART one byte at a time,
// keeping exactly one byte outstanding until its TX_DONE returns.
module bip_dbg_tx_seq
  import bip_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               tx_done_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  output logic               frame_done_o
);

  logic [FRAME_W-1:0] frame_q;
  logic [IDX_W-1:0]   idx_q;
  logic               pend_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic               accept;
  logic               last;

  // A TX_DONE with nothing outstanding is dropped here.
  assign accept       = tx_done_i && pend_q;
  assign last         = (idx_q == IDX_W'(FRAME_BYTES - 1));
  assign frame_done_o = accept && last;
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q    <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (clear_i) begin
        idx_q  <= '0;
        pend_q <= 1'b0;
      end else if (load_i) begin
        frame_q    <= frame_i << 8;
        tx_data_q  <= frame_i[FRAME_W-1 -: 8];
        idx_q      <= '0;
        pend_q     <= 1'b1;
        tx_start_q <= 1'b1;
      end else if (accept) begin
        if (last) begin
          pend_q <= 1'b0;
        end else begin
          idx_q      <= idx_q + IDX_W'(1);
          tx_data_q  <= frame_q[FRAME_W-1 -: 8];
          frame_q    <= frame_q << 8;
          tx_start_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bip_debug_ctrl.sv
// Run/step/report sequencer for the BIP core. Single-step support is
// built only when BIP_DBG_STEP_EN is defined.
module bip_debug_ctrl
  import bip_pkg::*;
#(
  parameter int PC_W  = 11,
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bip_debug_ctrl_if.slave   bus
);

  dbg_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cpu_rst_q;
  logic               busy_q;
  logic               halted_q;
  logic               cpu_en;
  logic               hlt;
  logic               frame_load;
  logic               frame_done;
  logic [PC_W-1:0]    pc;
  logic [ACC_W-1:0]   acc;
  logic [FRAME_W-1:0] frame;

  assign pc  = bus.pc;
  assign acc = bus.acc;
  assign hlt = (bus.opcode == OP_HLT);

`ifndef BIP_DBG_STEP_EN
  logic unused_step;
  assign unused_step = bus.step ^ bus.step_mode;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_CLEAR;
`ifdef BIP_DBG_STEP_EN
      ST_CLEAR:  state_d = bus.step_mode ? ST_STEP_WAIT : ST_RUN;
      ST_STEP_WAIT: if (hlt) state_d = ST_REPORT;
`else
      ST_CLEAR:  state_d = ST_RUN;
`endif
      ST_RUN:    if (hlt) state_d = ST_REPORT;
      ST_REPORT: if (frame_done) state_d = ST_DONE;
      ST_DONE:   if (bus.start) state_d = ST_CLEAR;
      default:   state_d = ST_IDLE;
    endcase
  end

  // HLT always blocks execution, including a coincident STEP.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN:       cpu_en = !hlt;
`ifdef BIP_DBG_STEP_EN
      ST_STEP_WAIT: cpu_en = bus.step && !hlt;
`endif
      default:      cpu_en = 1'b0;
    endcase
  end

  assign frame_load = (state_d == ST_REPORT) && (state_q != ST_REPORT);
  assign frame      = {8'(pc >> 8), pc[7:0], acc[15:8], acc[7:0],
                       cnt_q[15:8], cnt_q[7:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d == ST_IDLE) || (state_d == ST_CLEAR);
      busy_q    <= (state_d == ST_CLEAR) || (state_d == ST_RUN) ||
                   (state_d == ST_STEP_WAIT) || (state_d == ST_REPORT);
      halted_q  <= (state_d == ST_DONE);
      if (state_q == ST_CLEAR)
        cnt_q <= '0;
      else if (cpu_en && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  bip_dbg_tx_seq u_tx_seq (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (state_q == ST_CLEAR),
    .load_i       (frame_load),
    .frame_i      (frame),
    .tx_done_i    (bus.tx_done),
    .tx_data_o    (bus.tx_data),
    .tx_start_o   (bus.tx_start),
    .frame_done_o (frame_done)
  );

  assign bus.cpu_en  = cpu_en;
  assign bus.cpu_rst = cpu_rst_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Directed bench for bip_debug_ctrl; step checks follow BIP_DBG_STEP_EN.
module tb_bip_debug_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_start;
  int   n_en;
  int   base_en;
  int   base_start;

  bip_debug_ctrl_if bus ();

  bip_debug_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) n_start++;
    if (bus.cpu_en === 1'b1) n_en++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // START pulse, CLEAR, then n executing RUN cycles
  task automatic start_run(input string tag, input int n);
    bus.start  = 1'b1;
    bus.opcode = 5'h03;
    tick;
    bus.start = 1'b0;
    chk({tag, "_clr_rst"}, bus.cpu_rst, 1);
    chk({tag, "_clr_en"}, bus.cpu_en, 0);
    tick;
    chk({tag, "_run_rst"}, bus.cpu_rst, 0);
    for (int i = 0; i < n; i++) begin
      if (i < 3) chk({tag, "_run_en"}, bus.cpu_en, 1);
      tick;
    end
  endtask

  task automatic halt(input string tag, input logic [10:0] pc, input logic [15:0] acc);
    bus.pc     = pc;
    bus.acc    = acc;
    bus.opcode = 5'h00;
    #1;
    chk({tag, "_hlt_en"}, bus.cpu_en, 0);
    tick;
  endtask

  task automatic get_frame(input string tag, input logic [47:0] exp);
    for (int k = 0; k < 6; k++) begin
      int w;
      w = 0;
      while (bus.tx_start !== 1'b1 && w < 20) begin
        tick;
        w++;
      end
      chk($sformatf("%s_lat%0d", tag, k), w, 0);
      chk($sformatf("%s_b%0d", tag, k), bus.tx_data, exp[47-8*k -: 8]);
      tick;
      chk($sformatf("%s_pulse%0d", tag, k), bus.tx_start, 0);
      chk($sformatf("%s_busy%0d", tag, k), bus.busy, 1);
      tick;
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
    end
    chk({tag, "_halted"}, bus.halted, 1);
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_rst_end"}, bus.cpu_rst, 0);
    chk({tag, "_en_end"}, bus.cpu_en, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    n_start = 0;
    n_en = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.step_mode = 1'b0;
    bus.step = 1'b0;
    bus.opcode = 5'h01;
    bus.pc = '0;
    bus.acc = '0;
    bus.tx_done = 1'b0;

    // reset and idle
    tick;
    tick;
    rst = 1'b0;
    chk("rst_cpu_rst", bus.cpu_rst, 1);
    chk("rst_cpu_en", bus.cpu_en, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    base_start = n_start;
    for (int i = 0; i < 10; i++) tick;
    chk("idle_cpu_rst", bus.cpu_rst, 1);
    chk("idle_cpu_en", bus.cpu_en, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_no_tx", n_start - base_start, 0);

    // basic run: 5 instructions then HLT
    start_run("basic", 5);
    halt("basic", 11'h005, 16'h1234);
    get_frame("basic", 48'h00_05_12_34_00_05);

    // START and TX_DONE during RUN are ignored
    bus.start = 1'b1;
    bus.opcode = 5'h03;
    tick;
    bus.start = 1'b0;
    tick;
    base_en = n_en;
    base_start = n_start;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.tx_done = 1'b1;
    tick;
    bus.tx_done = 1'b0;
    tick;
    tick;
    chk("ign_busy", bus.busy, 1);
    chk("ign_en", bus.cpu_en, 1);
    chk("ign_no_tx", n_start - base_start, 0);
    chk("ign_en_cycles", n_en - base_en, 4);
    halt("ign", 11'h7FF, 16'h8001);
    get_frame("ign", 48'h07_FF_80_01_00_04);

`ifdef BIP_DBG_STEP_EN
    // single step: 3 STEP pulses, then HLT with coincident STEP
    bus.step_mode = 1'b1;
    bus.start = 1'b1;
    bus.opcode = 5'h03;
    tick;
    bus.start = 1'b0;
    tick;
    bus.step_mode = 1'b0;
    chk("step_wait_en", bus.cpu_en, 0);
    chk("step_wait_busy", bus.busy, 1);
    base_en = n_en;
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      #1;
      chk("step_en", bus.cpu_en, 1);
      tick;
      bus.step = 1'b0;
      tick;
      tick;
      tick;
    end
    bus.step = 1'b1;
    halt("step", 11'h7AB, 16'hBEEF);
    bus.step = 1'b0;
    chk("step_en_cycles", n_en - base_en, 3);
    get_frame("step", 48'h07_AB_BE_EF_00_03);
`else
    // STEP_MODE has no effect in this build
    bus.step_mode = 1'b1;
    start_run("nostep", 2);
    bus.step_mode = 1'b0;
    halt("nostep", 11'h7AB, 16'hBEEF);
    get_frame("nostep", 48'h07_AB_BE_EF_00_02);
`endif

    // reset in the middle of a frame
    start_run("abort", 3);
    halt("abort", 11'h123, 16'h0F0F);
    chk("abort_b0", bus.tx_data, 8'h01);
    tick;
    tick;
    bus.tx_done = 1'b1;
    tick;
    bus.tx_done = 1'b0;
    tick;
    bus.tx_done = 1'b1;
    tick;
    bus.tx_done = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_cpu_rst", bus.cpu_rst, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_halted", bus.halted, 0);
    chk("abort_tx_start", bus.tx_start, 0);
    chk("abort_tx_data", bus.tx_data, 0);
    base_start = n_start;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
    end
    chk("abort_no_tx", n_start - base_start, 0);
    chk("abort_idle_en", bus.cpu_en, 0);
    start_run("rerun", 2);
    halt("rerun", 11'h123, 16'h0F0F);
    get_frame("rerun", 48'h01_23_0F_0F_00_02);

    // counter saturation
    start_run("sat", 70000);
    halt("sat", 11'h400, 16'h00FF);
    get_frame("sat", 48'h04_00_00_FF_FF_FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
